// File: rtl/tx_arbiter.sv
// Round-robin byte arbiter: merges N_REQ byte streams into one downstream FIFO,
// holding each grant until end of message, burst cap, or stall timeout.
module tx_arbiter #(
    parameter int N_REQ        = 3,
    parameter int MAX_BURST    = 16,
    parameter int HOLD_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_last,
    output logic [N_REQ-1:0]     req_ready,
    input  logic                 full,
    output logic                 wr_en,
    output logic [7:0]           dout,
    output logic [1:0]           grant_id,
    output logic                 busy
);

    // Two-bit one-hot-style encoding so the illegal codes have a recovery path.
    typedef enum logic [1:0] {
        ST_ARB  = 2'b01,
        ST_XFER = 2'b10
    } state_t;

    localparam logic [7:0] MAX8  = 8'(MAX_BURST);
    localparam logic [7:0] HOLD8 = 8'(HOLD_TIMEOUT);
    localparam logic [2:0] NREQ3 = 3'(N_REQ);
    localparam logic [1:0] LAST_IDX = 2'(N_REQ - 1);

    state_t     r_state, w_state_next;
    logic [1:0] r_grant, w_grant_next;
    logic [1:0] r_rr_ptr, w_rr_next;
    logic [7:0] r_burst, w_burst_next;
    logic [7:0] r_idle, w_idle_next;

    logic [1:0] w_cand [N_REQ];
    logic       w_found;
    logic [1:0] w_pick;
    logic [7:0] w_gdata;
    logic       w_gvalid;
    logic       w_glast;
    logic [1:0] w_next_ptr;
    logic [7:0] w_burst_inc;

    // Candidate i is the requester i positions after rr_ptr, wrapped modulo N_REQ.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
            logic [2:0] w_sum;
            assign w_sum       = {1'b0, r_rr_ptr} + 3'(gi);
            assign w_cand[gi]  = (w_sum >= NREQ3) ? 2'(w_sum - NREQ3) : w_sum[1:0];
        end
    endgenerate

    always_comb begin
        w_found = 1'b0;
        w_pick  = r_rr_ptr;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[w_cand[i]]) begin
                w_found = 1'b1;
                w_pick  = w_cand[i];
            end
        end
    end

    assign w_gdata     = req_data[{r_grant, 3'b000} +: 8];
    assign w_gvalid    = req_valid[r_grant];
    assign w_glast     = req_last[r_grant];
    assign w_next_ptr  = (r_grant >= LAST_IDX) ? 2'd0 : r_grant + 2'd1;
    assign w_burst_inc = r_burst + 8'd1;

    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant;
        w_rr_next    = r_rr_ptr;
        w_burst_next = r_burst;
        w_idle_next  = r_idle;
        req_ready    = '0;
        wr_en        = 1'b0;
        dout         = 8'h00;

        case (r_state)
            ST_ARB: begin
                if (w_found) begin
                    w_grant_next = w_pick;
                    w_burst_next = 8'd0;
                    w_idle_next  = 8'd0;
                    w_state_next = ST_XFER;
                end
            end
            ST_XFER: begin
                if (r_idle >= HOLD8) begin
                    // Stalled grant revoked: no handshake is offered this cycle.
                    w_state_next = ST_ARB;
                    w_rr_next    = w_next_ptr;
                end else begin
                    req_ready[r_grant] = ~full;
                    if (w_gvalid && !full) begin
                        wr_en        = 1'b1;
                        dout         = w_gdata;
                        w_burst_next = w_burst_inc;
                        w_idle_next  = 8'd0;
                        if (w_glast || (w_burst_inc == MAX8)) begin
                            w_state_next = ST_ARB;
                            w_rr_next    = w_next_ptr;
                        end
                    end else begin
                        w_idle_next = r_idle + 8'd1;
                    end
                end
            end
            default: begin
                w_state_next = ST_ARB;
            end
        endcase

        // Reset is synchronous for state, but outputs must already be quiet in the reset cycle.
        if (reset) begin
            req_ready = '0;
            wr_en     = 1'b0;
            dout      = 8'h00;
        end
    end

    assign busy     = (r_state == ST_XFER) && !reset;
    assign grant_id = reset ? 2'd0 : r_grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_ARB;
            r_rr_ptr <= 2'd0;
            r_grant  <= 2'd0;
            r_burst  <= 8'd0;
            r_idle   <= 8'd0;
        end else begin
            r_state  <= w_state_next;
            r_rr_ptr <= w_rr_next;
            r_grant  <= w_grant_next;
            r_burst  <= w_burst_next;
            r_idle   <= w_idle_next;
        end
    end

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter: per-cycle checks of handshake, grant order,
// burst cap, backpressure, timeout and mid-burst reset.
module tb_tx_arbiter;
    localparam int N  = 3;
    localparam int MB = 16;
    localparam int HT = 64;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           full = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_last = '0;
    logic [N-1:0]   req_ready;
    logic           wr_en;
    logic [7:0]     dout;
    logic [1:0]     grant_id;
    logic           busy;

    int checks = 0;
    int errors = 0;

    // Per-requester byte sources consumed on each accepted handshake.
    logic [7:0] src_d [N][64];
    logic       src_l [N][64];
    int         src_n [N];
    int         src_p [N];

    logic         s_wr, s_busy;
    logic [7:0]   s_dout;
    logic [1:0]   s_gid;
    logic [N-1:0] s_ready;

    logic [1:0] log_id [128];
    logic [7:0] log_d  [128];
    int         log_n = 0;

    always #5 clk = ~clk;

    tx_arbiter #(.N_REQ(N), .MAX_BURST(MB), .HOLD_TIMEOUT(HT)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .full(full), .wr_en(wr_en),
        .dout(dout), .grant_id(grant_id), .busy(busy)
    );

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (src_p[i] < src_n[i]) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = src_d[i][src_p[i]];
                req_last[i]        = src_l[i][src_p[i]];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l);
        src_d[r][src_n[r]] = d;
        src_l[r][src_n[r]] = l;
        src_n[r]++;
    endtask

    // Sample one cycle at the falling edge, then advance sources past the rising edge.
    task automatic tick();
        logic [N-1:0] acc;
        @(negedge clk);
        s_wr    = wr_en;
        s_dout  = dout;
        s_busy  = busy;
        s_gid   = grant_id;
        s_ready = req_ready;
        acc     = req_valid & req_ready;
        if (wr_en && log_n < 128) begin
            log_id[log_n] = grant_id;
            log_d[log_n]  = dout;
            log_n++;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (acc[i]) src_p[i]++;
        drive();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        full  = 1'b0;
        for (int i = 0; i < N; i++) begin
            src_n[i] = 0;
            src_p[i] = 0;
        end
        drive();
        tick();
        tick();
        reset = 1'b0;
        log_n = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < N; i++) begin
            src_n[i] = 0;
            src_p[i] = 0;
            push(i, 8'hE0 + 8'(i), 1'b1);
        end
        drive();
        for (int t = 0; t < 2; t++) begin
            tick();
            checks++;
            if ({s_wr, s_busy, s_gid, s_ready, s_dout} !== 14'h0) begin
                errors++;
                $display("FAIL reset_outputs: got wr=%b busy=%b gid=%0d ready=%b dout=%h, expected all zero",
                         s_wr, s_busy, s_gid, s_ready, s_dout);
            end
        end
        for (int i = 0; i < N; i++) begin
            src_n[i] = 0;
            src_p[i] = 0;
        end
        drive();
        reset = 1'b0;
        for (int t = 0; t < 2; t++) begin
            tick();
            checks++;
            if ({s_wr, s_busy, s_gid, s_ready, s_dout} !== 14'h0) begin
                errors++;
                $display("FAIL post_reset_idle: got wr=%b busy=%b gid=%0d ready=%b dout=%h, expected all zero",
                         s_wr, s_busy, s_gid, s_ready, s_dout);
            end
        end
    endtask

    task automatic test_single();
        logic [4:0]  exp_wr   = 5'b01110;
        logic [39:0] exp_dout = 40'h00_41_42_43_00;
        do_reset();
        push(1, 8'h41, 1'b0);
        push(1, 8'h42, 1'b0);
        push(1, 8'h43, 1'b1);
        drive();
        for (int t = 0; t < 5; t++) begin
            tick();
            checks++;
            if (s_wr !== exp_wr[4-t] || s_busy !== exp_wr[4-t] || s_dout !== exp_dout[8*(4-t) +: 8]) begin
                errors++;
                $display("FAIL single_cycle%0d: got wr=%b busy=%b dout=%h, expected wr=%b busy=%b dout=%h",
                         t, s_wr, s_busy, s_dout, exp_wr[4-t], exp_wr[4-t], exp_dout[8*(4-t) +: 8]);
            end
            if (t >= 1 && t <= 3) begin
                checks++;
                if (s_gid !== 2'd1 || s_ready !== 3'b010) begin
                    errors++;
                    $display("FAIL single_grant%0d: got gid=%0d ready=%b, expected gid=1 ready=010",
                             t, s_gid, s_ready);
                end
            end
        end
        // rr_ptr now 2: with requesters 0 and 2 both waiting, 2 goes first.
        log_n = 0;
        push(0, 8'h0A, 1'b1);
        push(2, 8'h2A, 1'b1);
        drive();
        for (int t = 0; t < 5; t++) tick();
        checks++;
        if (log_n !== 2 || log_id[0] !== 2'd2 || log_d[0] !== 8'h2A || log_id[1] !== 2'd0 || log_d[1] !== 8'h0A) begin
            errors++;
            $display("FAIL single_rr_ptr: got n=%0d first=(%0d,%h) second=(%0d,%h), expected n=2 (2,2a) (0,0a)",
                     log_n, log_id[0], log_d[0], log_id[1], log_d[1]);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] g;
        logic [7:0] b;
        do_reset();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 6; k++) push(i, 8'(8'h10 * i + k), k[0]);
        drive();
        for (int t = 0; t < 28; t++) begin
            tick();
            checks++;
            if (s_busy !== (t % 3 != 0)) begin
                errors++;
                $display("FAIL rr_busy_cycle%0d: got %b, expected %b", t, s_busy, (t % 3 != 0));
            end
        end
        checks++;
        if (log_n !== 18) begin
            errors++;
            $display("FAIL rr_count: got %0d bytes, expected 18", log_n);
        end
        for (int j = 0; j < 18 && j < log_n; j++) begin
            g = 2'((j / 2) % 3);
            b = 8'(8'h10 * g + 2 * (j / 6) + (j % 2));
            checks++;
            if (log_id[j] !== g || log_d[j] !== b) begin
                errors++;
                $display("FAIL rr_byte%0d: got (%0d,%h), expected (%0d,%h)", j, log_id[j], log_d[j], g, b);
            end
        end
    endtask

    task automatic test_burst_cap();
        logic [1:0] g;
        logic [7:0] b;
        do_reset();
        for (int k = 0; k < 40; k++) push(0, 8'(8'h80 + k), 1'b0);
        push(2, 8'hC0, 1'b0);
        push(2, 8'hC1, 1'b1);
        drive();
        for (int t = 0; t < 50; t++) tick();
        checks++;
        if (log_n !== 42) begin
            errors++;
            $display("FAIL burst_count: got %0d bytes, expected 42", log_n);
        end
        for (int j = 0; j < 42 && j < log_n; j++) begin
            if (j < 16) begin
                g = 2'd0; b = 8'(8'h80 + j);
            end else if (j < 18) begin
                g = 2'd2; b = 8'(8'hC0 + j - 16);
            end else begin
                g = 2'd0; b = 8'(8'h80 + j - 2);
            end
            checks++;
            if (log_id[j] !== g || log_d[j] !== b) begin
                errors++;
                $display("FAIL burst_byte%0d: got (%0d,%h), expected (%0d,%h)", j, log_id[j], log_d[j], g, b);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int k = 0; k < 5; k++) push(1, 8'(8'h51 + k), (k == 4));
        drive();
        for (int t = 0; t < 12; t++) begin
            full = (t >= 3 && t <= 7);
            tick();
            if (t >= 3 && t <= 7) begin
                checks++;
                if (s_wr !== 1'b0 || s_ready !== 3'b000 || s_busy !== 1'b1 || s_dout !== 8'h00) begin
                    errors++;
                    $display("FAIL bp_stall%0d: got wr=%b ready=%b busy=%b dout=%h, expected 0 000 1 00",
                             t, s_wr, s_ready, s_busy, s_dout);
                end
            end
        end
        full = 1'b0;
        checks++;
        if (log_n !== 5) begin
            errors++;
            $display("FAIL bp_count: got %0d bytes, expected 5", log_n);
        end
        for (int j = 0; j < 5 && j < log_n; j++) begin
            checks++;
            if (log_d[j] !== 8'(8'h51 + j) || log_id[j] !== 2'd1) begin
                errors++;
                $display("FAIL bp_byte%0d: got (%0d,%h), expected (1,%h)", j, log_id[j], log_d[j], 8'(8'h51 + j));
            end
        end
    endtask

    task automatic test_timeout();
        int stray_wr = 0;
        do_reset();
        push(1, 8'h61, 1'b0);
        drive();
        for (int t = 0; t < 73; t++) begin
            if (t == 2) begin
                push(0, 8'h01, 1'b1);
                push(2, 8'h71, 1'b1);
                drive();
            end
            if (t == 66) begin
                push(1, 8'h62, 1'b1);
                drive();
            end
            tick();
            if (t >= 2 && t <= 66 && s_wr) stray_wr++;
            if (t == 10) begin
                checks++;
                if (s_ready !== 3'b010 || s_busy !== 1'b1 || s_gid !== 2'd1) begin
                    errors++;
                    $display("FAIL to_hold: got ready=%b busy=%b gid=%0d, expected 010 1 1", s_ready, s_busy, s_gid);
                end
            end
            if (t == 66) begin
                checks++;
                if (s_busy !== 1'b1 || s_ready !== 3'b000 || s_wr !== 1'b0) begin
                    errors++;
                    $display("FAIL to_revoke_cycle: got busy=%b ready=%b wr=%b, expected 1 000 0", s_busy, s_ready, s_wr);
                end
            end
            if (t == 67) begin
                checks++;
                if (s_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL to_arb: got busy=%b, expected 0", s_busy);
                end
            end
            if (t == 68 || t == 70 || t == 72) begin
                checks++;
                if (s_wr !== 1'b1 || s_gid !== (t == 68 ? 2'd2 : t == 70 ? 2'd0 : 2'd1) ||
                    s_dout !== (t == 68 ? 8'h71 : t == 70 ? 8'h01 : 8'h62)) begin
                    errors++;
                    $display("FAIL to_next_grant_t%0d: got wr=%b gid=%0d dout=%h", t, s_wr, s_gid, s_dout);
                end
            end
        end
        checks++;
        if (stray_wr !== 0) begin
            errors++;
            $display("FAIL to_no_write: got %0d writes while stalled, expected 0", stray_wr);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        for (int k = 0; k < 5; k++) push(1, 8'(8'h91 + k), (k == 4));
        push(2, 8'hA1, 1'b1);
        drive();
        for (int t = 0; t < 6; t++) begin
            reset = (t == 3);
            tick();
            if (t == 3 || t == 4) begin
                checks++;
                if ({s_wr, s_busy, s_gid, s_ready, s_dout} !== 14'h0) begin
                    errors++;
                    $display("FAIL rst_mid_t%0d: got wr=%b busy=%b gid=%0d ready=%b dout=%h, expected all zero",
                             t, s_wr, s_busy, s_gid, s_ready, s_dout);
                end
            end
        end
        reset = 1'b0;
        checks++;
        if (s_wr !== 1'b1 || s_gid !== 2'd1 || s_dout !== 8'h93) begin
            errors++;
            $display("FAIL rst_mid_regrant: got wr=%b gid=%0d dout=%h, expected 1 1 93", s_wr, s_gid, s_dout);
        end
        checks++;
        if (log_n !== 3 || log_d[0] !== 8'h91 || log_d[1] !== 8'h92) begin
            errors++;
            $display("FAIL rst_mid_log: got n=%0d d0=%h d1=%h, expected 3 91 92", log_n, log_d[0], log_d[1]);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            src_n[i] = 0;
            src_p[i] = 0;
        end
        test_reset();
        test_single();
        test_round_robin();
        test_burst_cap();
        test_backpressure();
        test_timeout();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tx_arbiter.md
TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 3: number of byte requesters; index 0 = bootloader, 1 = core print, 2 = debug/status.
REQ-002 Parameter MAX_BURST, default 16: maximum bytes per grant; legal range 1..255.
REQ-003 Parameter HOLD_TIMEOUT, default 64: idle cycles before a stalled grant is revoked; legal range 1..255.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  N_REQ  per-requester byte valid.
REQ-007 req_data  input  8*N_REQ  per-requester byte; requester i owns bits [8i+7:8i].
REQ-008 req_last  input  N_REQ  marks the final byte of a requester's message.
REQ-009 req_ready  output  N_REQ  per-requester accept; one-hot or zero.
REQ-010 full  input  1  downstream FIFO full.
REQ-011 wr_en  output  1  downstream FIFO write strobe.
REQ-012 dout  output  8  downstream FIFO write data.
REQ-013 grant_id  output  2  index of the current grant holder; valid only while busy=1.
REQ-014 busy  output  1  high in XFER state.

Function
REQ-015 States: ARB and XFER, held in a registered state variable; any unreachable encoding recovers to ARB on the next cycle.
REQ-016 In ARB, if any req_valid is high, the block registers the first requester with valid=1 found scanning from rr_ptr upward, modulo N_REQ, into grant_id and enters XFER; otherwise it stays in ARB.
REQ-017 ARB never asserts req_ready or wr_en; arbitration costs exactly one cycle between grants.
REQ-018 In XFER, req_ready[grant_id] = ~full, combinationally; all other req_ready bits are 0.
REQ-019 A transfer occurs in a cycle where req_valid[grant_id] & req_ready[grant_id]; that cycle wr_en=1 and dout=req_data[grant_id], with zero latency.
REQ-020 wr_en is never 1 while full=1, and never 1 outside a transfer cycle.
REQ-021 dout = 8'h00 whenever wr_en=0.
REQ-022 burst_cnt (8 bits) clears on entry to XFER and increments by 1 per transfer.
REQ-023 XFER exits to ARB after the cycle in which a transfer has req_last=1, or after the transfer that makes burst_cnt reach MAX_BURST, whichever comes first.
REQ-024 idle_cnt (8 bits) clears on every transfer and on entry to XFER, and increments on every XFER cycle without a transfer; cycles stalled by full count as idle.
REQ-025 When idle_cnt reaches HOLD_TIMEOUT, XFER exits to ARB on the next cycle and no transfer occurs in that cycle.
REQ-026 On every XFER->ARB exit, rr_ptr <= (grant_id+1) mod N_REQ.
REQ-027 If req_last coincides with burst_cnt reaching MAX_BURST, the block exits exactly once and advances rr_ptr once.
REQ-028 A requester dropping req_valid mid-burst keeps the grant, subject to the REQ-025 timeout.
REQ-029 A requester may not change req_data or req_last while req_valid=1 and req_ready=0; the block does not check this.
REQ-030 Changes to non-granted requesters' inputs have no effect during XFER.

Reset
REQ-031 While reset=1 on a clock edge: state <= ARB, rr_ptr <= 0, grant_id <= 0, burst_cnt <= 0, idle_cnt <= 0.
REQ-032 Outputs during reset and the first cycle after it: wr_en=0, dout=8'h00, req_ready=0, busy=0, grant_id=0.
REQ-033 Reset asserted mid-burst aborts the grant; no transfer occurs in the reset cycle, and the interrupted requester gets no priority afterwards.

Verification
REQ-034 Single requester: req 1 sends 3 bytes 0x41,0x42,0x43 with last on 0x43, full=0 -> busy rises 1 cycle after valid; wr_en high 3 consecutive cycles; dout sequence 41,42,43; rr_ptr=2.
REQ-035 Round robin: all 3 requesters continuously valid, each message 2 bytes -> grant order 0,1,2,0,...; exactly one idle ARB cycle between grants; no byte loss or reordering.
REQ-036 Burst cap: req 0 streams 40 bytes with no last, MAX_BURST=16, req 2 also valid -> grants 0(16 bytes), 2, then 0 resumes; byte order of req 0 preserved.
REQ-037 Backpressure: full=1 for 5 cycles mid-burst -> wr_en=0 and req_ready=0 for those 5 cycles; the pending byte is written exactly once after full falls.
REQ-038 Timeout: granted req 1 drops valid for HOLD_TIMEOUT cycles -> the grant is released and req 2 is granted next.
REQ-039 Reset mid-burst after 2 of 5 bytes -> outputs return to reset values next cycle; the next grant goes to the lowest valid index.
